branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution unit for the 64-bit RV core. At fetch it looks up the current PC in a direct-mapped branch history/target table and supplies a taken prediction and next-PC target. In execute it consumes the resolved outcome from the branch comparator (`BrE`) and target adder. It then trains the table and raises a registered flush with the corrected PC on a misprediction.

## Interface

- `ENTRIES`, default 16: number of table entries. Must be a power of 2, ≥2. `IDX_W = log2(ENTRIES)`.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `IF_PC` input, 64 bits: fetch-stage PC to look up.
- `PredTaken` output, 1 bit: combinational prediction for `IF_PC`.
- `PredTarget` output, 64 bits: combinational predicted next PC for `IF_PC`.
- `EX_Valid` input, 1 bit: a conditional branch is resolving in execute this cycle.
- `EX_PC` input, 64 bits: PC of the resolving branch.
- `EX_BrE` input, 1 bit: actual outcome from the branch comparator (1 = taken).
- `EX_Target` input, 64 bits: actual taken target (PC + B-immediate).
- `EX_PredTaken` input, 1 bit: the prediction issued at fetch for this branch, piped down.
- `EX_PredTarget` input, 64 bits: the predicted next PC issued at fetch, piped down.
- `Flush` output, 1 bit: registered one-cycle misprediction pulse.
- `FlushPC` output, 64 bits: registered correct next PC, valid when `Flush`=1.
- `BrCount` output, 32 bits: number of resolved branches, saturating.
- `MissCount` output, 32 bits: number of mispredictions, saturating.

## Operation

- Table entry fields: `valid`, `tag` (PC[63:IDX_W+2]), `target` (64 bits), `ctr` (2-bit saturating counter).
- Index = PC[IDX_W+1:2]. PC[1:0] is ignored everywhere.
- Lookup (combinational, from registered state): hit = `valid[idx]` && tag match.
  - `PredTaken` = hit && `ctr[1]`.
  - `PredTarget` = `target` when `PredTaken`, else `IF_PC`+4, computed mod 2^64.
- Resolution (when `EX_Valid`=1): actual next PC = `EX_Target` if `EX_BrE`, else `EX_PC`+4.
  - Mispredict = (`EX_PredTaken` != `EX_BrE`) or (`EX_BrE` && `EX_PredTaken` && `EX_PredTarget` != `EX_Target`).
- Training at the edge (when `EX_Valid`=1), looked up at `EX_PC`:
  - Hit: `ctr` increments if taken (saturates at 3) and decrements if not taken (saturates at 0). `target` is written with `EX_Target` when taken.
  - Miss and taken: allocate the entry, overwriting any occupant. Set valid=1, tag, target=`EX_Target`, ctr=2'b10 (weakly taken).
  - Miss and not taken: no table change.
- Counters: `BrCount` increments on each `EX_Valid`. `MissCount` increments on each mispredict. Both hold at 32'hFFFF_FFFF.
- With `EX_Valid`=0, the table, counters and outputs are unchanged, except `Flush`, which returns to 0.

## Timing

- Reset values (asynchronous): all `valid`=0, all `ctr`=2'b01, `tag`/`target`=0, `Flush`=0, `FlushPC`=0, `BrCount`=0, `MissCount`=0.
  - Consequence: `PredTaken`=0 and `PredTarget`=`IF_PC`+4 immediately after reset.
- Lookup latency: 0 cycles (combinational from `IF_PC`).
- Flush latency: `Flush`/`FlushPC` are registered. They assert in the cycle after the edge that samples the mispredicting `EX_Valid`, for exactly 1 cycle per mispredict.
  - Back-to-back mispredicts give back-to-back `Flush` pulses, each with its own `FlushPC`.
- Table and counter writes become visible to lookup the cycle after the update edge.
  - A same-cycle lookup of the entry being written sees the old contents (read-before-write). No bypass.
- `FlushPC` holds its last value while `Flush`=0.
- Reset asserted mid-operation clears everything immediately, including a pending `Flush`. The first post-reset edge behaves as a fresh start.
- PC+4 wraps: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle with `IF_PC`=0x1000 → `PredTaken`=0, `PredTarget`=0x1004, `Flush`=0, counters 0, all with no clock edge.
- **Cold miss, taken:** `EX_Valid`=1, `EX_PC`=0x1000, `EX_BrE`=1, `EX_Target`=0x2000, `EX_PredTaken`=0.
  - Next cycle: `Flush`=1, `FlushPC`=0x2000, `MissCount`=1, `BrCount`=1.
  - Afterwards, `IF_PC`=0x1000 gives `PredTaken`=1, `PredTarget`=0x2000.
- **Counter training:** from ctr=2'b10 at 0x1000, resolve not-taken twice → `PredTaken`=0 after the first; ctr=2'b00 after the second.
  - Then three taken resolutions → ctr saturates at 2'b11.
  - `FlushPC`=0x1004 on each mispredicted not-taken.
- **Aliasing:** with `ENTRIES`=16, train 0x1000 taken, then resolve 0x1040 (same index, different tag) taken to 0x3000.
  - Lookup 0x1000 → miss (`PredTaken`=0).
  - Lookup 0x1040 → `PredTarget`=0x3000.
- **Target mismatch:** `EX_PredTaken`=1, `EX_PredTarget`=0x2000, `EX_BrE`=1, `EX_Target`=0x2400 → `Flush`=1, `FlushPC`=0x2400, table target becomes 0x2400.
  - Same case with matching targets → `Flush`=0, `MissCount` unchanged.
- **Read-before-write and wrap:** lookup `IF_PC`=0x1000 in the same cycle as a training write to 0x1000 → old prediction returned that cycle, new one the next.
  - `IF_PC`=64'hFFFF_FFFF_FFFF_FFFC on a miss → `PredTarget`=0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table with 2-bit counters.
// Predicts at fetch, trains at execute, flushes on mispredict.
module branch_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] IF_PC,
    output logic        PredTaken,
    output logic [63:0] PredTarget,
    input  logic        EX_Valid,
    input  logic [63:0] EX_PC,
    input  logic        EX_BrE,
    input  logic [63:0] EX_Target,
    input  logic        EX_PredTaken,
    input  logic [63:0] EX_PredTarget,
    output logic        Flush,
    output logic [63:0] FlushPC,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
);

    localparam int TAG_W = 64 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [63:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic        flush_q;
    logic [63:0] flush_pc_q, flush_pc_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic [63:0]      ex_next;
    logic             mispredict;
    logic [1:0]       ctr_d;

    // PC[1:0] never participates in indexing, tagging or training
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

    assign if_idx = IF_PC[IDX_W+1:2];
    assign if_tag = IF_PC[63:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign PredTaken  = if_hit && ctr_q[if_idx][1];
    assign PredTarget = PredTaken ? target_q[if_idx] : IF_PC + 64'd4;

    assign ex_idx = EX_PC[IDX_W+1:2];
    assign ex_tag = EX_PC[63:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign ex_next    = EX_BrE ? EX_Target : EX_PC + 64'd4;
    assign mispredict = (EX_PredTaken != EX_BrE) ||
                        (EX_BrE && EX_PredTaken && (EX_PredTarget != EX_Target));

    always_comb begin
        ctr_d = ctr_q[ex_idx];
        if (!ex_hit) begin
            ctr_d = 2'b10;
        end else if (EX_BrE) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        flush_pc_d = flush_pc_q;
        if (EX_Valid) begin
            if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
            if (mispredict) begin
                flush_pc_d = ex_next;
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (EX_Valid && (ex_hit || EX_BrE)) begin
            // A miss that is taken allocates; a hit always trains the counter
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            ctr_q[ex_idx]   <= ctr_d;
            if (EX_BrE) target_q[ex_idx] <= EX_Target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            flush_q    <= EX_Valid && mispredict;
            flush_pc_q <= flush_pc_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign Flush     = flush_q;
    assign FlushPC   = flush_pc_q;
    assign BrCount   = br_cnt_q;
    assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (ENTRIES=16).
// Expected values are worked out by hand from the table/counter rules.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] IF_PC = 64'h1000;
    logic        PredTaken;
    logic [63:0] PredTarget;
    logic        EX_Valid = 1'b0;
    logic [63:0] EX_PC = '0;
    logic        EX_BrE = 1'b0;
    logic [63:0] EX_Target = '0;
    logic        EX_PredTaken = 1'b0;
    logic [63:0] EX_PredTarget = '0;
    logic        Flush;
    logic [63:0] FlushPC;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .IF_PC         (IF_PC),
        .PredTaken     (PredTaken),
        .PredTarget    (PredTarget),
        .EX_Valid      (EX_Valid),
        .EX_PC         (EX_PC),
        .EX_BrE        (EX_BrE),
        .EX_Target     (EX_Target),
        .EX_PredTaken  (EX_PredTaken),
        .EX_PredTarget (EX_PredTarget),
        .Flush         (Flush),
        .FlushPC       (FlushPC),
        .BrCount       (BrCount),
        .MissCount     (MissCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one resolving branch for one edge, then idles EX
    task automatic resolve(input logic [63:0] pc, input logic bre,
                           input logic [63:0] tgt, input logic ptk,
                           input logic [63:0] ptgt);
        EX_Valid      = 1'b1;
        EX_PC         = pc;
        EX_BrE        = bre;
        EX_Target     = tgt;
        EX_PredTaken  = ptk;
        EX_PredTarget = ptgt;
        step();
        EX_Valid = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [63:0] pc,
                          input logic tk, input logic [63:0] tgt);
        IF_PC = pc;
        #1;
        check({tag, "_tk"}, {63'd0, PredTaken}, {63'd0, tk});
        check({tag, "_tgt"}, PredTarget, tgt);
    endtask

    task automatic flushchk(input string tag, input logic f,
                            input logic [63:0] pc, input int br,
                            input int miss);
        check({tag, "_flush"}, {63'd0, Flush}, {63'd0, f});
        check({tag, "_fpc"}, FlushPC, pc);
        check({tag, "_br"}, {32'd0, BrCount}, 64'(br));
        check({tag, "_miss"}, {32'd0, MissCount}, 64'(miss));
    endtask

    initial begin
        step();
        step();
        #2 rst = 1'b0;
        step();

        // cold miss, taken
        resolve(64'h1000, 1'b1, 64'h2000, 1'b0, 64'h1004);
        flushchk("cold0", 1'b1, 64'h2000, 1, 1);
        lookup("cold0_lk", 64'h1000, 1'b1, 64'h2000);

        // asynchronous reset mid-cycle with a pending Flush
        #2 rst = 1'b1;
        #1;
        flushchk("rst", 1'b0, 64'h0, 0, 0);
        lookup("rst_lk", 64'h1000, 1'b0, 64'h1004);
        #1 rst = 1'b0;
        step();

        resolve(64'h1000, 1'b1, 64'h2000, 1'b0, 64'h1004);
        flushchk("cold", 1'b1, 64'h2000, 1, 1);
        lookup("cold_lk", 64'h1000, 1'b1, 64'h2000);

        // same-cycle lookup sees old entry; back-to-back flush
        IF_PC         = 64'h1000;
        EX_Valid      = 1'b1;
        EX_PC         = 64'h1000;
        EX_BrE        = 1'b0;
        EX_Target     = 64'h2000;
        EX_PredTaken  = 1'b1;
        EX_PredTarget = 64'h2000;
        #1;
        check("rbw_old_tk", {63'd0, PredTaken}, 64'd1);
        check("rbw_old_tgt", PredTarget, 64'h2000);
        step();
        EX_Valid = 1'b0;
        flushchk("nt1", 1'b1, 64'h1004, 2, 2);
        lookup("nt1_lk", 64'h1000, 1'b0, 64'h1004);

        resolve(64'h1000, 1'b0, 64'h2000, 1'b0, 64'h1004);
        flushchk("nt2", 1'b0, 64'h1004, 3, 2);
        lookup("nt2_lk", 64'h1000, 1'b0, 64'h1004);

        // ctr 00 -> 01 -> 10 -> 11 -> 11 (saturated)
        resolve(64'h1000, 1'b1, 64'h2000, 1'b0, 64'h1004);
        flushchk("t1", 1'b1, 64'h2000, 4, 3);
        lookup("t1_lk", 64'h1000, 1'b0, 64'h1004);
        resolve(64'h1000, 1'b1, 64'h2000, 1'b0, 64'h1004);
        flushchk("t2", 1'b1, 64'h2000, 5, 4);
        lookup("t2_lk", 64'h1000, 1'b1, 64'h2000);
        resolve(64'h1000, 1'b1, 64'h2000, 1'b1, 64'h2000);
        flushchk("t3", 1'b0, 64'h2000, 6, 4);
        resolve(64'h1000, 1'b1, 64'h2000, 1'b1, 64'h2000);
        flushchk("t4", 1'b0, 64'h2000, 7, 4);
        resolve(64'h1000, 1'b0, 64'h2000, 1'b1, 64'h2000);
        flushchk("sat_nt", 1'b1, 64'h1004, 8, 5);
        lookup("sat_lk", 64'h1000, 1'b1, 64'h2000);

        // wrong target on a correctly predicted taken branch
        resolve(64'h1000, 1'b1, 64'h2400, 1'b1, 64'h2000);
        flushchk("tmis", 1'b1, 64'h2400, 9, 6);
        lookup("tmis_lk", 64'h1000, 1'b1, 64'h2400);
        resolve(64'h1000, 1'b1, 64'h2400, 1'b1, 64'h2400);
        flushchk("tok", 1'b0, 64'h2400, 10, 6);

        // aliasing: 0x1040 shares index 0 with 0x1000
        resolve(64'h1040, 1'b1, 64'h3000, 1'b0, 64'h1044);
        flushchk("alias", 1'b1, 64'h3000, 11, 7);
        lookup("alias_old", 64'h1000, 1'b0, 64'h1004);
        lookup("alias_new", 64'h1040, 1'b1, 64'h3000);

        // miss and not taken leaves the table alone
        resolve(64'h1004, 1'b0, 64'h5000, 1'b0, 64'h1008);
        flushchk("mnt", 1'b0, 64'h3000, 12, 7);
        lookup("mnt_lk", 64'h1004, 1'b0, 64'h1008);

        // PC+4 wraps at the top of the address space
        lookup("wrap_lk", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
        resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h10, 1'b1, 64'h10);
        flushchk("wrap_fl", 1'b1, 64'h0, 13, 8);

        // idle edge drops Flush and holds FlushPC
        step();
        flushchk("idle", 1'b0, 64'h0, 13, 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
